icnd_read_arbiter: RTL and testbench
====================================

ICND_READ_ARBITER -- requirements
Module: icnd_read_arbiter

Interface
REQ-001 Parameter CHANNELS, default 4: number of icnd2110 output channels sharing one frame-buffer read port (2..8).
REQ-002 Parameter ADDRESS_BUS_WIDTH, default 16: width of every read address.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: watchdog limit, used only when the watchdog is compiled in.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ch_read_request  input  CHANNELS  per-channel read request, level, bit i = channel i.
REQ-007 ch_read_address  input  CHANNELS*ADDRESS_BUS_WIDTH  packed per-channel addresses, channel i at bits [i*W +: W].
REQ-008 ch_read_data  output  16  read data broadcast to all channels.
REQ-009 ch_read_finished_strobe  output  CHANNELS  one-cycle data-ready strobe, only the granted channel's bit set.
REQ-010 mem_read_address  output  ADDRESS_BUS_WIDTH  address to shared memory.
REQ-011 mem_read_request  output  1  level request to memory, held until completion.
REQ-012 mem_read_data  input  16  memory data, valid with the finished strobe.
REQ-013 mem_read_finished_strobe  input  1  one-cycle memory completion.
REQ-014 grant  output  log2(CHANNELS)  index of the channel currently owning the memory port.
REQ-015 timeout_error  output  1  sticky watchdog flag (constant 0 without the watchdog).

Function
REQ-016 The state machine SHALL have four states: IDLE, ISSUE, DELIVER, HOLDOFF.
REQ-017 IDLE: if any eligible request exists, the arbiter SHALL choose round-robin, starting at (last_grant+1) mod CHANNELS. It SHALL latch grant and that channel's address into mem_read_address, then go to ISSUE the next cycle.
REQ-018 ISSUE: mem_read_request SHALL be 1. The address SHALL be held stable, even if ch_read_address changes, until mem_read_finished_strobe is seen.
REQ-019 On mem_read_finished_strobe in ISSUE, the arbiter SHALL register mem_read_data into ch_read_data, deassert mem_read_request the next cycle, and go to DELIVER.
REQ-020 DELIVER: ch_read_finished_strobe[grant] SHALL be 1 for exactly one cycle. Latency from the memory strobe to the channel strobe is 1 cycle. Next state is HOLDOFF.
REQ-021 HOLDOFF: one cycle with no request. The just-served channel SHALL be ineligible in the following IDLE arbitration cycle only, so it can update its fifo-full request. Next state is IDLE.
REQ-022 Minimum service period per read SHALL be 4 cycles plus memory latency. With all channels requesting, each channel SHALL be served once per CHANNELS grants (no starvation).
REQ-023 ch_read_data SHALL hold its last value outside DELIVER. A mem_read_finished_strobe outside ISSUE SHALL be ignored.
REQ-024 When a request drops while its channel is granted, the cycle SHALL still complete and be delivered.
REQ-025 Round-robin wrap: after grant CHANNELS-1, the search SHALL start at 0.

Reset
REQ-026 On rst, all outputs SHALL clear immediately: state IDLE, mem_read_request 0, mem_read_address 0, ch_read_finished_strobe 0, ch_read_data 0, grant 0, last_grant CHANNELS-1 (so channel 0 wins first), timeout_error 0.
REQ-027 Reset mid-ISSUE SHALL abandon the transfer. A memory strobe arriving after reset release SHALL be ignored per REQ-023.

Configuration
REQ-028 Macro ICND_READ_ARBITER_WATCHDOG_EN. When defined, a counter SHALL run in ISSUE. After TIMEOUT_CYCLES cycles without a memory strobe, the arbiter SHALL deliver 16'h0000 through DELIVER and set timeout_error, which stays set until rst. When undefined, ISSUE SHALL wait indefinitely and timeout_error SHALL be tied to 0.

Verification
REQ-029 Single request: ch_read_request=0001, address 0x0005, memory answers 3 cycles later with 0xBEEF -> mem_read_address=0x0005, ch_read_data=0xBEEF, ch_read_finished_strobe=0001 for 1 cycle.
REQ-030 All four requesting continuously -> grant sequence 0,1,2,3,0,..., with no channel served twice in a row.
REQ-031 Channel 2 changes its address during ISSUE -> mem_read_address stays at the originally latched value.
REQ-032 rst asserted during ISSUE, then a late memory strobe -> no channel strobe, and mem_read_request=0.
REQ-033 With WATCHDOG_EN and TIMEOUT_CYCLES=8, memory never answers -> 0x0000 delivered after 8 cycles and timeout_error=1. Without the macro, the arbiter stays in ISSUE.

Source files
------------

// File: rtl/icnd_read_arbiter_if.sv
// Bundle of channel-side and memory-side read signals for icnd_read_arbiter.
// Latency: none (wires only).
// Backpressure: level requests held by channels/arbiter until the matching finished strobe.
interface icnd_read_arbiter_if #(
  parameter int CHANNELS          = 4,
  parameter int ADDRESS_BUS_WIDTH = 16
);
  localparam int GRANT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]                   ch_read_request;
  logic [CHANNELS*ADDRESS_BUS_WIDTH-1:0] ch_read_address;
  logic [15:0]                           ch_read_data;
  logic [CHANNELS-1:0]                   ch_read_finished_strobe;
  logic [ADDRESS_BUS_WIDTH-1:0]          mem_read_address;
  logic                                  mem_read_request;
  logic [15:0]                           mem_read_data;
  logic                                  mem_read_finished_strobe;
  logic [GRANT_W-1:0]                    grant;
  logic                                  timeout_error;

  // Arbiter view: takes channel requests and memory completions, drives the rest.
  modport slave (
    input  ch_read_request, ch_read_address, mem_read_data, mem_read_finished_strobe,
    output ch_read_data, ch_read_finished_strobe, mem_read_address, mem_read_request,
           grant, timeout_error
  );

  // Environment view: channels plus shared memory.
  modport master (
    output ch_read_request, ch_read_address, mem_read_data, mem_read_finished_strobe,
    input  ch_read_data, ch_read_finished_strobe, mem_read_address, mem_read_request,
           grant, timeout_error
  );
endinterface

// File: rtl/icnd_read_arbiter.sv
// Round-robin arbiter sharing one frame-buffer read port among CHANNELS icnd2110 channels.
// Latency: IDLE->ISSUE 1 cycle, memory strobe -> channel strobe 1 cycle, min period 4 + memory latency.
// Backpressure: ISSUE holds mem_read_request/address until the memory strobe; optional watchdog macro ICND_READ_ARBITER_WATCHDOG_EN.
module icnd_read_arbiter #(
  parameter int CHANNELS          = 4,
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic               clk,
  input  logic               rst,
  icnd_read_arbiter_if.slave bus
);

  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = ADDRESS_BUS_WIDTH;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                mreq_q, mreq_d;
  logic [15:0]         rdata_q, rdata_d;
  logic [CHANNELS-1:0] fin_q, fin_d;
  logic                mask_q, mask_d;

  logic [CHANNELS-1:0] eligible;
  logic                pick_vld;
  logic [GW-1:0]       pick_idx;
  logic [GW-1:0]       rr_sel;
  int                  rr_idx;
  logic                timeout_hit;

  // Round-robin search from last_grant+1; the channel served just before is masked for one IDLE cycle.
  always_comb begin
    eligible = bus.ch_read_request;
    if (mask_q) eligible[last_grant_q] = 1'b0;
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_idx   = 0;
    rr_sel   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      rr_idx = (int'(last_grant_q) + k) % CHANNELS;
      rr_sel = GW'(rr_idx);
      if (!pick_vld && eligible[rr_sel]) begin
        pick_vld = 1'b1;
        pick_idx = rr_sel;
      end
    end
  end

  // Next-state and datapath updates for the four-state read cycle.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    mreq_d       = mreq_q;
    rdata_d      = rdata_q;
    fin_d        = '0;
    mask_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          addr_d       = bus.ch_read_address[int'(pick_idx)*AW +: AW];
          mreq_d       = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Address is only captured in IDLE, so channel address changes here have no effect.
        if (bus.mem_read_finished_strobe) begin
          rdata_d         = bus.mem_read_data;
          mreq_d          = 1'b0;
          fin_d[grant_q]  = 1'b1;
          state_d         = ST_DELIVER;
        end else if (timeout_hit) begin
          rdata_d         = 16'h0000;
          mreq_d          = 1'b0;
          fin_d[grant_q]  = 1'b1;
          state_d         = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        // Give the served channel one cycle to refresh its fifo-full driven request.
        mask_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset leaves last_grant at the top channel so channel 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(CHANNELS - 1);
      addr_q       <= '0;
      mreq_q       <= 1'b0;
      rdata_q      <= '0;
      fin_q        <= '0;
      mask_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      mreq_q       <= mreq_d;
      rdata_q      <= rdata_d;
      fin_q        <= fin_d;
      mask_q       <= mask_d;
    end
  end

`ifdef ICND_READ_ARBITER_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;

  assign timeout_hit = (state_q == ST_ISSUE) && !bus.mem_read_finished_strobe &&
                       (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Count ISSUE cycles without a memory answer; the error flag is sticky until reset.
  always_comb begin
    wd_cnt_d = '0;
    if ((state_q == ST_ISSUE) && !bus.mem_read_finished_strobe && !timeout_hit) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    wd_err_d = wd_err_q | timeout_hit;
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign bus.timeout_error = wd_err_q;
`else
  // Without the watchdog ISSUE waits for memory forever; the parameter is kept for build compatibility.
  assign timeout_hit       = 1'b0;
  assign bus.timeout_error = (TIMEOUT_CYCLES < 0);
`endif

  assign bus.grant                   = grant_q;
  assign bus.mem_read_address        = addr_q;
  assign bus.mem_read_request        = mreq_q;
  assign bus.ch_read_data            = rdata_q;
  assign bus.ch_read_finished_strobe = fin_q;

endmodule

// File: tb/tb_icnd_read_arbiter.sv
// Directed self-checking bench for icnd_read_arbiter (4 channels, 16-bit addresses).
// Latency: checks sample outputs 1 ns after each rising edge.
// Backpressure: the bench plays the shared memory and answers requests after a chosen delay.
`timescale 1ns/1ps
module tb_icnd_read_arbiter;
  localparam int CH = 4;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  icnd_read_arbiter_if #(.CHANNELS(CH), .ADDRESS_BUS_WIDTH(AW)) bus ();

  icnd_read_arbiter #(
    .CHANNELS(CH), .ADDRESS_BUS_WIDTH(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int ch, input logic [15:0] a);
    bus.ch_read_address[ch*AW +: AW] = a;
  endtask

  task automatic clear_inputs();
    bus.ch_read_request          = '0;
    bus.ch_read_address          = '0;
    bus.mem_read_data            = '0;
    bus.mem_read_finished_strobe = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Plays memory for one read: waits for the request, answers after lat cycles, reports DELIVER outputs.
  task automatic serve(input logic [15:0] d, input int lat, output bit ok,
                       output logic [1:0] g, output logic [15:0] a,
                       output logic [3:0] fin, output logic [15:0] rd, output logic mreq);
    int n;
    n = 0; ok = 1'b0; g = '0; a = '0; fin = '0; rd = '0; mreq = 1'b1;
    while (bus.mem_read_request !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.mem_read_request !== 1'b1) return;
    g = bus.grant;
    a = bus.mem_read_address;
    repeat (lat - 1) tick();
    bus.mem_read_data            = d;
    bus.mem_read_finished_strobe = 1'b1;
    tick();
    bus.mem_read_finished_strobe = 1'b0;
    fin  = bus.ch_read_finished_strobe;
    rd   = bus.ch_read_data;
    mreq = bus.mem_read_request;
    ok   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++; if (bus.mem_read_request !== 1'b0) begin failures++; $display("FAIL reset_mreq: got %b want 0", bus.mem_read_request); end
    checks++; if (bus.mem_read_address !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h want 0000", bus.mem_read_address); end
    checks++; if (bus.ch_read_finished_strobe !== 4'b0000) begin failures++; $display("FAIL reset_fin: got %b want 0000", bus.ch_read_finished_strobe); end
    checks++; if (bus.ch_read_data !== 16'h0000) begin failures++; $display("FAIL reset_data: got %h want 0000", bus.ch_read_data); end
    checks++; if (bus.grant !== 2'd0) begin failures++; $display("FAIL reset_grant: got %0d want 0", bus.grant); end
    checks++; if (bus.timeout_error !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", bus.timeout_error); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit ok; logic [1:0] g; logic [15:0] a; logic [3:0] fin; logic [15:0] rd; logic mreq;
    set_addr(0, 16'h0005);
    bus.ch_read_request = 4'b0001;
    serve(16'hBEEF, 3, ok, g, a, fin, rd, mreq);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_req: no memory request seen"); end
    checks++; if (g !== 2'd0) begin failures++; $display("FAIL single_grant: got %0d want 0", g); end
    checks++; if (a !== 16'h0005) begin failures++; $display("FAIL single_addr: got %h want 0005", a); end
    checks++; if (fin !== 4'b0001) begin failures++; $display("FAIL single_fin: got %b want 0001", fin); end
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL single_data: got %h want beef", rd); end
    checks++; if (mreq !== 1'b0) begin failures++; $display("FAIL single_mreq_drop: got %b want 0", mreq); end
    tick();
    bus.ch_read_request = 4'b0000;
    checks++; if (bus.ch_read_finished_strobe !== 4'b0000) begin failures++; $display("FAIL single_fin_one_cycle: got %b want 0000", bus.ch_read_finished_strobe); end
    checks++; if (bus.ch_read_data !== 16'hBEEF) begin failures++; $display("FAIL single_data_hold: got %h want beef", bus.ch_read_data); end
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    bit ok; logic [1:0] g; logic [15:0] a; logic [3:0] fin; logic [15:0] rd; logic mreq;
    logic [1:0] eg; logic [15:0] ea; logic [15:0] ed; logic [3:0] ef;
    do_reset();
    for (int i = 0; i < CH; i++) set_addr(i, 16'h0100 + 16'(i));
    bus.ch_read_request = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      eg = 2'(n % 4);
      ea = 16'h0100 + 16'(n % 4);
      ed = 16'hA000 + 16'(n);
      ef = 4'b0001 << (n % 4);
      serve(ed, 1 + (n % 3), ok, g, a, fin, rd, mreq);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rr_req[%0d]: no memory request seen", n); end
      checks++; if (g !== eg) begin failures++; $display("FAIL rr_grant[%0d]: got %0d want %0d", n, g, eg); end
      checks++; if (a !== ea) begin failures++; $display("FAIL rr_addr[%0d]: got %h want %h", n, a, ea); end
      checks++; if (fin !== ef) begin failures++; $display("FAIL rr_fin[%0d]: got %b want %b", n, fin, ef); end
      checks++; if (rd !== ed) begin failures++; $display("FAIL rr_data[%0d]: got %h want %h", n, rd, ed); end
    end
    bus.ch_read_request = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic test_holdoff();
    bit ok; logic [1:0] g; logic [15:0] a; logic [3:0] fin; logic [15:0] rd; logic mreq;
    set_addr(1, 16'h0011);
    bus.ch_read_request = 4'b0010;
    serve(16'h1111, 1, ok, g, a, fin, rd, mreq);
    checks++; if (g !== 2'd1) begin failures++; $display("FAIL holdoff_grant: got %0d want 1", g); end
    tick();
    tick();
    tick();
    checks++; if (bus.mem_read_request !== 1'b0) begin failures++; $display("FAIL holdoff_masked_idle: got %b want 0", bus.mem_read_request); end
    tick();
    checks++; if (bus.mem_read_request !== 1'b1) begin failures++; $display("FAIL holdoff_regrant: got %b want 1", bus.mem_read_request); end
    checks++; if (bus.grant !== 2'd1) begin failures++; $display("FAIL holdoff_regrant_idx: got %0d want 1", bus.grant); end
    bus.ch_read_request = 4'b0000;
    serve(16'h1234, 2, ok, g, a, fin, rd, mreq);
    checks++; if (fin !== 4'b0010) begin failures++; $display("FAIL drop_still_delivered: got %b want 0010", fin); end
    repeat (3) tick();
  endtask

  task automatic test_addr_hold();
    int n;
    set_addr(2, 16'h0222);
    bus.ch_read_request = 4'b0100;
    n = 0;
    while (bus.mem_read_request !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (bus.mem_read_request !== 1'b1) begin failures++; $display("FAIL hold_req: got %b want 1", bus.mem_read_request); end
    set_addr(2, 16'h0999);
    bus.ch_read_request = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.mem_read_address !== 16'h0222) begin failures++; $display("FAIL hold_addr[%0d]: got %h want 0222", k, bus.mem_read_address); end
      checks++; if (bus.mem_read_request !== 1'b1) begin failures++; $display("FAIL hold_mreq[%0d]: got %b want 1", k, bus.mem_read_request); end
    end
    bus.mem_read_data = 16'h2222;
    bus.mem_read_finished_strobe = 1'b1;
    tick();
    bus.mem_read_finished_strobe = 1'b0;
    checks++; if (bus.ch_read_finished_strobe !== 4'b0100) begin failures++; $display("FAIL hold_fin: got %b want 0100", bus.ch_read_finished_strobe); end
    checks++; if (bus.ch_read_data !== 16'h2222) begin failures++; $display("FAIL hold_data: got %h want 2222", bus.ch_read_data); end
    repeat (3) tick();
  endtask

  task automatic test_ignored_strobe();
    bus.mem_read_data = 16'hDEAD;
    bus.mem_read_finished_strobe = 1'b1;
    tick();
    bus.mem_read_finished_strobe = 1'b0;
    tick();
    checks++; if (bus.ch_read_finished_strobe !== 4'b0000) begin failures++; $display("FAIL idle_strobe_fin: got %b want 0000", bus.ch_read_finished_strobe); end
    checks++; if (bus.ch_read_data !== 16'h2222) begin failures++; $display("FAIL idle_strobe_data: got %h want 2222", bus.ch_read_data); end
  endtask

  task automatic test_reset_mid_issue();
    int n;
    set_addr(3, 16'h0333);
    bus.ch_read_request = 4'b1000;
    n = 0;
    while (bus.mem_read_request !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (bus.grant !== 2'd3) begin failures++; $display("FAIL rstmid_grant: got %0d want 3", bus.grant); end
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_read_request !== 1'b0) begin failures++; $display("FAIL rstmid_mreq: got %b want 0", bus.mem_read_request); end
    checks++; if (bus.mem_read_address !== 16'h0000) begin failures++; $display("FAIL rstmid_addr: got %h want 0000", bus.mem_read_address); end
    checks++; if (bus.grant !== 2'd0) begin failures++; $display("FAIL rstmid_grant_clr: got %0d want 0", bus.grant); end
    bus.ch_read_request = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    bus.mem_read_data = 16'h5555;
    bus.mem_read_finished_strobe = 1'b1;
    tick();
    bus.mem_read_finished_strobe = 1'b0;
    checks++; if (bus.ch_read_finished_strobe !== 4'b0000) begin failures++; $display("FAIL late_strobe_fin: got %b want 0000", bus.ch_read_finished_strobe); end
    checks++; if (bus.ch_read_data !== 16'h0000) begin failures++; $display("FAIL late_strobe_data: got %h want 0000", bus.ch_read_data); end
    checks++; if (bus.mem_read_request !== 1'b0) begin failures++; $display("FAIL late_strobe_mreq: got %b want 0", bus.mem_read_request); end
    tick();
  endtask

  task automatic test_watchdog();
    int n;
    logic [3:0] seen;
    do_reset();
    set_addr(1, 16'h0044);
    bus.ch_read_request = 4'b0010;
    n = 0;
    while (bus.mem_read_request !== 1'b1 && n < 20) begin tick(); n++; end
    bus.ch_read_request = 4'b0000;
`ifdef ICND_READ_ARBITER_WATCHDOG_EN
    n = 0;
    while (bus.ch_read_finished_strobe === 4'b0000 && n < 40) begin tick(); n++; end
    checks++; if (n !== 8) begin failures++; $display("FAIL wd_latency: got %0d want 8", n); end
    checks++; if (bus.ch_read_finished_strobe !== 4'b0010) begin failures++; $display("FAIL wd_fin: got %b want 0010", bus.ch_read_finished_strobe); end
    checks++; if (bus.ch_read_data !== 16'h0000) begin failures++; $display("FAIL wd_data: got %h want 0000", bus.ch_read_data); end
    checks++; if (bus.timeout_error !== 1'b1) begin failures++; $display("FAIL wd_error: got %b want 1", bus.timeout_error); end
    repeat (4) tick();
    checks++; if (bus.timeout_error !== 1'b1) begin failures++; $display("FAIL wd_sticky: got %b want 1", bus.timeout_error); end
`else
    seen = '0;
    for (int k = 0; k < 40; k++) begin
      tick();
      seen = seen | bus.ch_read_finished_strobe;
    end
    checks++; if (bus.mem_read_request !== 1'b1) begin failures++; $display("FAIL nowd_wait: got %b want 1", bus.mem_read_request); end
    checks++; if (seen !== 4'b0000) begin failures++; $display("FAIL nowd_fin: got %b want 0000", seen); end
    checks++; if (bus.timeout_error !== 1'b0) begin failures++; $display("FAIL nowd_error: got %b want 0", bus.timeout_error); end
`endif
    do_reset();
    checks++; if (bus.timeout_error !== 1'b0) begin failures++; $display("FAIL wd_reset_clear: got %b want 0", bus.timeout_error); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_holdoff();
    test_addr_hold();
    test_ignored_strobe();
    test_reset_mid_issue();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
